gaus_clt_sampler: RTL and testbench
===================================

Name: gaus_clt_sampler

Overview:
- Consumes the free-running 56-bit pseudo-random word from the upstream LFSR stage.
- Builds an approximately Gaussian signed sample by the central limit theorem: it sums 7 uniform bytes per word over N_WORDS consecutive words, then subtracts the mean.
- Applies a runtime gain shift with saturation.
- Delivers samples to the LBM collision/forcing stage for thermal-noise injection, using a valid/ready handshake.

Parameters:
- N_WORDS, 4, number of consecutive 56-bit words summed per sample (≥1).
- OUT_W, 16, width of the signed output sample.
- CNT_W, 16, width of the delivered-sample counter.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous reset, active-low; sampled on rising Clk.
- rand_in  in  56  LFSR output; new value every cycle, no valid qualifier.
- run  in  1  enables accumulation.
- gain  in  3  left-shift amount applied to the centered sum (0..7).
- sample_out  out  OUT_W  signed Gaussian sample, two's complement.
- sample_valid  out  1  sample_out holds an undelivered sample.
- sample_ready  in  1  consumer accepts sample_out this cycle.
- busy  out  1  high in ACCUM or HOLD.
- sample_cnt  out  CNT_W  count of completed handshakes; wraps.

Behaviour:
- Reset (Reset=0 at an edge) forces:
  - state=IDLE, acc=0, cnt=0, sample_out=0, sample_valid=0, sample_cnt=0.
  - This applies mid-operation too; any partial or held sum is discarded.
- Word sum (combinational): wsum = sum of the 7 unsigned bytes rand_in[8k+7:8k], k=0..6; range 0..1785.
- Accumulator width must hold N_WORDS·1785 without overflow.
- OFFSET = floor(N_WORDS·7·255/2); equals 3570 for N_WORDS=4.
- Output computation, evaluated on completion of a sum S:
  - c = S − OFFSET, signed.
  - v = c << gain, using the gain value present in the load cycle.
  - v saturates to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- slot_free = !sample_valid || sample_ready.
- States:
  - IDLE:
    - acc=0, cnt=0.
    - If run=1, go to ACCUM; that same cycle is not accumulated.
  - ACCUM:
    - If run=0, discard the partial sum (acc=0, cnt=0) and go to IDLE.
    - Else, if cnt<N_WORDS−1: acc+=wsum, cnt++.
    - Else (final word), S=acc+wsum:
      - If slot_free: load sample_out=v(S), sample_valid=1, acc=0, cnt=0; stay in ACCUM. Accumulation is back-to-back with no bubble.
      - If not slot_free: acc=S, go to HOLD.
  - HOLD:
    - rand_in is ignored and run is ignored.
    - When slot_free: load sample_out=v(acc), sample_valid=1, acc=0, cnt=0.
    - Next state is ACCUM if run=1, else IDLE.
- Handshake:
  - On valid&&ready at an edge: sample_cnt++ (wrapping), and sample_valid clears unless a new sample loads in the same cycle.
  - A simultaneous load and accept replaces the sample; sample_valid stays 1.
  - sample_out and sample_valid are stable while valid&&!ready.
- Latency:
  - With run=1 at the edge entering ACCUM (edge E0), words are sampled at edges E1..E_N.
  - sample_valid rises after E_N.
  - In steady state with ready=1, one sample is produced every N_WORDS cycles.
- busy = (state != IDLE).

Test Plan:
- Reset release with run=1, rand_in=all ones, gain=0, ready=1:
  - sample_valid rises after edge E4.
  - sample_out=+3570 (0x0DF2).
  - Thereafter one sample every 4 cycles; sample_cnt increments on each handshake.
- rand_in all ones:
  - gain=3 → sample_out=28560.
  - gain=4 → 32767 (saturated).
- rand_in all zeros:
  - gain=0 → −3570.
  - gain=4 → −32768 (saturated).
- rand_in=0x80 in every byte, gain=0 → sample_out=+14.
- Backpressure:
  - Hold ready=0 after the first sample. The first sample stays stable, the next sum completes, state=HOLD, and rand_in changes have no effect.
  - Raise ready for one cycle: sample_cnt+1, the held sum loads at the same edge, sample_valid stays 1.
- Abort cases:
  - Drop run after 2 words: state=IDLE and no sample. Re-raising run yields a sample built from 4 fresh words.
  - Assert Reset while in HOLD: sample_valid=0, sample_out=0, sample_cnt=0 at the next edge.

Source files
------------

// File: rtl/gaus_clt_sampler.sv
// rtl/gaus_clt_sampler.sv - CLT Gaussian noise sampler fed by a 56-bit LFSR word
// Sums 7 bytes over N_WORDS words, centres, gain-shifts and saturates into a valid/ready slot.
module gaus_clt_sampler #(
  parameter int N_WORDS = 4,
  parameter int OUT_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [55:0]      rand_in,
  input  logic             run,
  input  logic [2:0]       gain,
  output logic [OUT_W-1:0] sample_out,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt
);

  localparam int WS_W     = 11;
  localparam int ACC_MAX  = N_WORDS * 1785;
  localparam int ACC_W    = $clog2(ACC_MAX + 1);
  localparam int OFFSET   = (N_WORDS * 7 * 255) / 2;
  localparam int CNT_BITS = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  // Wide enough for the centred sum shifted by the maximum gain of 7.
  localparam int VW       = (ACC_W + 8 > OUT_W + 1) ? ACC_W + 8 : OUT_W + 1;

  localparam logic signed [VW-1:0]   SAT_MAX  = VW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [VW-1:0]   SAT_MIN  = ~SAT_MAX;
  localparam logic signed [VW-1:0]   OFFSET_V = VW'(OFFSET);
  localparam logic [CNT_BITS-1:0]    LAST_CNT = CNT_BITS'(N_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_BITS-1:0] cnt_q;
  logic [OUT_W-1:0]   sample_out_q;
  logic               sample_valid_q;
  logic [CNT_W-1:0]   sample_cnt_q;

  logic [WS_W-1:0]    wsum;
  logic [ACC_W-1:0]   sum_d;
  logic               slot_free;

  always_comb begin
    wsum = '0;
    for (int k = 0; k < 7; k++) begin
      wsum = wsum + WS_W'(rand_in[8*k +: 8]);
    end
  end

  assign sum_d     = acc_q + ACC_W'(wsum);
  assign slot_free = !sample_valid_q || sample_ready;

  function automatic logic [OUT_W-1:0] scale(input logic [ACC_W-1:0] s, input logic [2:0] g);
    logic signed [VW-1:0] c;
    logic signed [VW-1:0] v;
    c = signed'(VW'(s)) - OFFSET_V;
    v = c <<< g;
    if (v > SAT_MAX) begin
      return SAT_MAX[OUT_W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[OUT_W-1:0];
    end else begin
      return v[OUT_W-1:0];
    end
  endfunction

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q        <= S_IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      sample_cnt_q   <= '0;
    end else begin
      // Accept first; a load later in this block overrides the clear.
      if (sample_valid_q && sample_ready) begin
        sample_cnt_q   <= sample_cnt_q + CNT_W'(1);
        sample_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          acc_q <= '0;
          cnt_q <= '0;
          if (run) state_q <= S_ACCUM;
        end
        S_ACCUM: begin
          if (!run) begin
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q < LAST_CNT) begin
            acc_q <= sum_d;
            cnt_q <= cnt_q + CNT_BITS'(1);
          end else if (slot_free) begin
            sample_out_q   <= scale(sum_d, gain);
            sample_valid_q <= 1'b1;
            acc_q          <= '0;
            cnt_q          <= '0;
          end else begin
            acc_q   <= sum_d;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (slot_free) begin
            sample_out_q   <= scale(acc_q, gain);
            sample_valid_q <= 1'b1;
            acc_q          <= '0;
            cnt_q          <= '0;
            state_q        <= run ? S_ACCUM : S_IDLE;
          end
        end
        default: begin
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign sample_cnt   = sample_cnt_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_gaus_clt_sampler.sv
// tb/tb_gaus_clt_sampler.sv - directed self-checking bench for gaus_clt_sampler
module tb_gaus_clt_sampler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [55:0] rand_in;
  logic        run;
  logic [2:0]  gain;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        busy;
  logic [15:0] sample_cnt;

  int checks_total  = 0;
  int checks_passed = 0;

  localparam logic [55:0] ONES = {56{1'b1}};
  localparam logic [55:0] ZERO = 56'd0;
  localparam logic [55:0] HALF = {7{8'h80}};

  gaus_clt_sampler #(.N_WORDS(4), .OUT_W(16), .CNT_W(16)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .rand_in      (rand_in),
    .run          (run),
    .gain         (gain),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .sample_cnt   (sample_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    Reset = 1'b0; run = 1'b1; rand_in = ONES; gain = 3'd0; sample_ready = 1'b1;
    step(2);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_out",   32'(sample_out),   32'd0);
    check("rst_cnt",   32'(sample_cnt),   32'd0);
    check("rst_busy",  32'(busy),         32'd0);

    Reset = 1'b1;
    step(1);                                  // E0: enter ACCUM
    check("e0_busy",   32'(busy),         32'd1);
    step(3);                                  // E3
    check("e3_valid",  32'(sample_valid), 32'd0);
    step(1);                                  // E4
    check("e4_valid",  32'(sample_valid), 32'd1);
    check("e4_out",    32'(sample_out),   32'h0DF2);
    check("e4_cnt",    32'(sample_cnt),   32'd0);
    step(3);                                  // E7
    check("e7_valid",  32'(sample_valid), 32'd0);
    check("e7_cnt",    32'(sample_cnt),   32'd1);
    step(1);                                  // E8
    check("e8_valid",  32'(sample_valid), 32'd1);
    check("e8_out",    32'(sample_out),   32'h0DF2);

    gain = 3'd3;
    step(4);                                  // E12
    check("g3_out",    32'(sample_out),   32'h6F90);
    check("g3_cnt",    32'(sample_cnt),   32'd2);
    gain = 3'd4;
    step(4);                                  // E16
    check("g4_sat_hi", 32'(sample_out),   32'h7FFF);
    rand_in = ZERO; gain = 3'd0;
    step(4);                                  // E20
    check("zero_out",  32'(sample_out),   32'hF20E);
    gain = 3'd4;
    step(4);                                  // E24
    check("g4_sat_lo", 32'(sample_out),   32'h8000);
    check("e24_cnt",   32'(sample_cnt),   32'd5);
    rand_in = HALF; gain = 3'd0;
    step(4);                                  // E28
    check("half_out",  32'(sample_out),   32'h000E);
    check("e28_cnt",   32'(sample_cnt),   32'd6);

    // Backpressure: sample 14 must hold while an all-ones sum parks in HOLD.
    sample_ready = 1'b0; rand_in = ONES;
    step(4);                                  // E32: enter HOLD
    check("bp_out",    32'(sample_out),   32'h000E);
    check("bp_valid",  32'(sample_valid), 32'd1);
    check("bp_busy",   32'(busy),         32'd1);
    rand_in = ZERO; gain = 3'd0;
    step(2);                                  // E34
    check("hold_out",  32'(sample_out),   32'h000E);
    check("hold_cnt",  32'(sample_cnt),   32'd6);
    sample_ready = 1'b1;
    step(1);                                  // E35: accept + load
    sample_ready = 1'b0;
    check("rel_cnt",   32'(sample_cnt),   32'd7);
    check("rel_valid", 32'(sample_valid), 32'd1);
    check("rel_out",   32'(sample_out),   32'h0DF2);
    step(4);                                  // E39: HOLD again
    check("h2_out",    32'(sample_out),   32'h0DF2);
    check("h2_busy",   32'(busy),         32'd1);

    Reset = 1'b0;
    step(1);                                  // E40
    check("rh_valid",  32'(sample_valid), 32'd0);
    check("rh_out",    32'(sample_out),   32'd0);
    check("rh_cnt",    32'(sample_cnt),   32'd0);
    check("rh_busy",   32'(busy),         32'd0);

    // Abort after two words; the re-run must use four fresh words only.
    Reset = 1'b1; run = 1'b0; sample_ready = 1'b1;
    step(1);
    run = 1'b1; rand_in = ONES;
    step(3);                                  // E0 + two words
    run = 1'b0;
    step(1);
    check("ab_busy",   32'(busy),         32'd0);
    check("ab_valid",  32'(sample_valid), 32'd0);
    run = 1'b1; rand_in = HALF;
    step(4);
    check("rr_valid0", 32'(sample_valid), 32'd0);
    step(1);
    check("rr_valid1", 32'(sample_valid), 32'd1);
    check("rr_out",    32'(sample_out),   32'h000E);
    step(1);
    check("rr_cnt",    32'(sample_cnt),   32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
